quad_velocity_decoder: RTL
==========================

// Module: quad_velocity_decoder
// PURPOSE
//  Parametrised quadrature encoder front end: synchronises and glitch-filters A/B (optionally Z),
//  decodes x4 steps into a wrapping position counter, flags illegal transitions and reports a
//  signed, scaled velocity once per fixed time window. Sits between the encoder pins and the
//  motion/velocity-curve logic; supersedes the fixed-width 1497-count decoder.
// PARAMETERS
//  CNT_W       16      position width
//  CPR         1497    counts per revolution; position range 0..CPR-1 (CPR <= 2**CNT_W)
//  WIN_CYC     131072  clk cycles per velocity window
//  SYNC_STAGES 2       synchroniser flops per input (>=2)
//  FILT_LEN    3       input must be stable FILT_LEN consecutive cycles to be accepted (>=1)
//  VEL_W       16      signed velocity / step-accumulator width
//  SCALE_NUM   29      velocity multiplier, 1..255
//  SCALE_SHIFT 3       velocity = (steps*SCALE_NUM) >>> SCALE_SHIFT  (29/8 = 3.625)
// PORTS
//  clk       in   1      clock
//  rst       in   1      reset, asynchronous, active-high
//  quad_a    in   1      encoder A, asynchronous
//  quad_b    in   1      encoder B, asynchronous
//  quad_z    in   1      encoder index; ignored unless QUAD_INDEX_EN
//  clr       in   1      synchronous position clear
//  position  out  CNT_W  current position
//  velocity  out  VEL_W  signed steps-per-window, scaled, held between updates
//  vel_valid out  1      one-cycle pulse when velocity updates
//  dir       out  1      1 = last legal step forward
//  err       out  1      one-cycle pulse on illegal transition
//  err_cnt   out  8      illegal transitions seen, saturates at 255
// BEHAVIOUR
//  - Reset: position 0, velocity 0, vel_valid 0, dir 0, err 0, err_cnt 0, window counter 0,
//    accumulator 0, filter/sync flops 0, primed flag 0. Reset mid-window aborts the window.
//  - Input latency: SYNC_STAGES + FILT_LEN cycles pin -> filtered state; one more to position.
//  - First filtered sample after reset only loads the previous-state register (primed<=1);
//    no decode, no err, regardless of pin levels.
//  - State {A,B}; forward sequence 00->10->11->01->00 = +1, reverse = -1, unchanged = none,
//    both bits changed in one filtered update = err pulse, err_cnt+1 (sat), position unchanged.
//  - Wrap: +1 at CPR-1 -> 0; -1 at 0 -> CPR-1. Never leaves 0..CPR-1.
//  - Position priority: rst > clr > index (if enabled) > step. Step on a clr/index cycle is
//    dropped from position but still counted in the velocity accumulator and dir.
//  - Velocity: signed accumulator sums steps, saturating at +/-(2**(VEL_W-1)-1). When window
//    counter == WIN_CYC-1: velocity <= sat_VEL_W((acc+step_this_cycle)*SCALE_NUM >>> SCALE_SHIFT)
//    (shift rounds toward -inf), vel_valid=1 next cycle edge, acc <= 0, counter <= 0.
//  - Step-based accumulation, so no wrap ambiguity across CPR boundary.
// CONFIGURATION
//  QUAD_INDEX_EN defined: quad_z passes through same sync+filter; filtered Z rising edge sets
//    position <= 0 (priority above). Undefined: no Z logic, quad_z unconnected internally.
// STRUCTURE
//  - Package quad_pkg: STEP_NONE/STEP_FWD/STEP_REV/STEP_ERR encodings, sat_signed function,
//    clog2 function for window-counter width.
//  - Sub-module quad_input_filter (1-bit sync chain + stability counter), one per input.
//  - Top: decode, position, error counter, window/velocity pipeline.
// TESTING (sim: WIN_CYC=64, other defaults)
//  1 Hold A=B=1 through reset release -> err=0, err_cnt=0, position=0 after 10 cycles.
//  2 1500 forward steps from 0 -> position=3, dir=1; then 4 reverse from 0 -> position=1493, dir=0.
//  3 16 forward steps in one window -> velocity=58, vel_valid high exactly 1 cycle; 16 reverse -> -58.
//  4 2-cycle glitch on A -> no step; A and B toggled same cycle -> err pulse, err_cnt=1, position held.
//  5 clr and forward step same cycle at position 700 -> position=0, window acc still +1.
//  6 QUAD_INDEX_EN: Z pulse (4 cycles) at position 700 -> position=0; undefined -> stays 700.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature velocity decoder: step encodings,
// a signed saturation helper and a ceil-log2 helper used to size counters.
package quad_pkg;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_REV  = 2'd2,
      STEP_ERR  = 2'd3
   } step_t;

   // Bits needed to hold the values 0..v-1 (never less than one bit).
   function automatic int clog2(input int unsigned v);
      int          r;
      int unsigned p;
      r = 1;
      p = 2;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // Clamp a wide signed value to the symmetric range +/-(2**(w-1)-1).
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int unsigned w);
      logic signed [63:0] lim;
      lim = (64'sd1 <<< (w - 1)) - 64'sd1;
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      else
         return v;
   endfunction

endpackage

// File: rtl/quad_input_filter.sv
// One-bit input conditioner: a reset-to-zero synchroniser chain followed by a
// stability filter that accepts a new level only after it has been seen on
// FILT_LEN consecutive cycles.
module quad_input_filter
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_din,
   output logic o_dout
);

   localparam int            CW   = clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_filt;
   logic                   w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign o_dout = r_filt;

   // Metastability chain: shift the raw pin in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
   end

   // Count consecutive cycles the synchronised level differs from the output;
   // any return to the current output level restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_filt <= 1'b0;
      end else if (w_sync == r_filt) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_filt <= w_sync;
         r_cnt  <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/quad_velocity_decoder.sv
// Quadrature encoder front end: filtered A/B decode (x4) into a wrapping
// position counter, illegal-transition flagging with a saturating count, and a
// scaled signed velocity reported once per WIN_CYC-cycle window.
// Build option: define QUAD_INDEX_EN to filter quad_z and zero the position on
// its rising edge; without it quad_z is ignored.
module quad_velocity_decoder
   import quad_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int CPR         = 1497,
   parameter int WIN_CYC     = 131072,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3,
   parameter int VEL_W       = 16,
   parameter int SCALE_NUM   = 29,
   parameter int SCALE_SHIFT = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_quad_a,
   input  logic                    i_quad_b,
   input  logic                    i_quad_z,
   input  logic                    i_clr,
   output logic [CNT_W-1:0]        o_position,
   output logic signed [VEL_W-1:0] o_velocity,
   output logic                    o_vel_valid,
   output logic                    o_dir,
   output logic                    o_err,
   output logic [7:0]              o_err_cnt
);

   // Cycles from reset release until the filters reflect the pins.
   localparam int                 WARM     = SYNC_STAGES + FILT_LEN;
   localparam int                 WARM_W   = clog2(WARM + 1);
   localparam logic [WARM_W-1:0]  WARM_END = WARM_W'(WARM);
   localparam int                 WIN_W    = clog2(WIN_CYC);
   localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WIN_CYC - 1);
   localparam logic [CNT_W-1:0]   POS_MAX  = CNT_W'(CPR - 1);

   logic w_a, w_b, w_index;
   logic [1:0] w_cur;
   step_t w_step;

   logic [1:0]              r_prev;
   logic                    r_primed;
   logic [WARM_W-1:0]       r_warm;
   logic [CNT_W-1:0]        r_pos;
   logic                    r_dir;
   logic                    r_err;
   logic [7:0]              r_err_cnt;
   logic [WIN_W-1:0]        r_win;
   logic signed [VEL_W-1:0] r_acc;
   logic signed [VEL_W-1:0] r_vel;
   logic                    r_vel_valid;

   logic signed [63:0] w_delta, w_sum, w_scaled, w_vel_sat, w_acc_sat;

   quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
      .clk(clk), .rst(rst), .i_din(i_quad_a), .o_dout(w_a));
   quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
      .clk(clk), .rst(rst), .i_din(i_quad_b), .o_dout(w_b));

`ifdef QUAD_INDEX_EN
   logic w_z, r_z_prev;
   quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_z (
      .clk(clk), .rst(rst), .i_din(i_quad_z), .o_dout(w_z));
   // Remember the filtered index level to detect its rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_z_prev <= 1'b0;
      else     r_z_prev <= w_z;
   end
   assign w_index = w_z & ~r_z_prev;
`else
   logic w_unused_z;
   assign w_unused_z = i_quad_z;
   assign w_index    = 1'b0;
`endif

   assign w_cur = {w_a, w_b};

   // Classify the filtered {A,B} transition; nothing is decoded until primed.
   always_comb begin
      w_step = STEP_NONE;
      if (r_primed) begin
         case ({r_prev, w_cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: w_step = STEP_FWD;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: w_step = STEP_REV;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: w_step = STEP_ERR;
            default:                            w_step = STEP_NONE;
         endcase
      end
   end

   // Wait for the filter pipeline to fill, then load the first sample as the
   // previous state; afterwards track the filtered state every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_warm   <= '0;
         r_primed <= 1'b0;
         r_prev   <= 2'b00;
      end else if (!r_primed) begin
         if (r_warm == WARM_END) begin
            r_primed <= 1'b1;
            r_prev   <= w_cur;
         end else begin
            r_warm <= r_warm + WARM_W'(1);
         end
      end else begin
         r_prev <= w_cur;
      end
   end

   // Position: clear beats index beats step; wraps within 0..CPR-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pos <= '0;
      end else if (i_clr || w_index) begin
         r_pos <= '0;
      end else if (w_step == STEP_FWD) begin
         r_pos <= (r_pos == POS_MAX) ? '0 : r_pos + CNT_W'(1);
      end else if (w_step == STEP_REV) begin
         r_pos <= (r_pos == '0) ? POS_MAX : r_pos - CNT_W'(1);
      end
   end

   // Direction of the last legal step, error pulse and saturating error count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dir     <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= 8'd0;
      end else begin
         r_err <= (w_step == STEP_ERR);
         if (w_step == STEP_FWD) r_dir <= 1'b1;
         if (w_step == STEP_REV) r_dir <= 1'b0;
         if (w_step == STEP_ERR && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   // Window arithmetic in a wide signed domain so the final step and the
   // scale multiply can never overflow before saturation.
   always_comb begin
      w_delta = 64'sd0;
      if (w_step == STEP_FWD) w_delta = 64'sd1;
      if (w_step == STEP_REV) w_delta = -64'sd1;
      w_sum     = 64'(r_acc) + w_delta;
      w_scaled  = (w_sum * 64'(SCALE_NUM)) >>> SCALE_SHIFT;
      w_vel_sat = sat_signed(w_scaled, VEL_W);
      w_acc_sat = sat_signed(w_sum, VEL_W);
   end

   // Window counter and accumulator; publish the scaled velocity at window end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win       <= '0;
         r_acc       <= '0;
         r_vel       <= '0;
         r_vel_valid <= 1'b0;
      end else if (r_win == WIN_LAST) begin
         r_win       <= '0;
         r_acc       <= '0;
         r_vel       <= w_vel_sat[VEL_W-1:0];
         r_vel_valid <= 1'b1;
      end else begin
         r_win       <= r_win + WIN_W'(1);
         r_acc       <= w_acc_sat[VEL_W-1:0];
         r_vel_valid <= 1'b0;
      end
   end

   assign o_position  = r_pos;
   assign o_velocity  = r_vel;
   assign o_vel_valid = r_vel_valid;
   assign o_dir       = r_dir;
   assign o_err       = r_err;
   assign o_err_cnt   = r_err_cnt;

endmodule
